floor_palette_fader: RTL
========================

Name: floor_palette_fader

Overview:
- Runtime palette controller for the floor layer.
- Holds a 16-entry writable 12-bit RGB palette, initialised to the default floor grey ramp.
- Serves pixel lookups through a 2-stage pipeline.
- A fade FSM scales every looked-up colour by a global brightness that steps once per N frames; this drives level-transition fade-in/fade-out.
- Sits between the floor tile ROM index output and the VGA colour mux.

Parameters:
- FADE_FRAMES, 4: frame_start pulses per brightness step (>=1).
- IDX_W, 4: palette index width (depth = 2**IDX_W).
- COLOR_W, 4: bits per colour channel.

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  synchronous, active-low reset
- frame_start  in  1  one-cycle pulse at the start of vertical blank
- pix_valid  in  1  lookup request qualifier
- pix_index  in  IDX_W  palette index to look up
- wr_en  in  1  palette write strobe
- wr_addr  in  IDX_W  palette entry to write
- wr_data  in  3*COLOR_W  {R,G,B} value to write
- fade_in  in  1  pulse: ramp brightness toward 15
- fade_out  in  1  pulse: ramp brightness toward 0
- rgb_valid  out  1  pix_valid delayed 2 cycles
- red, green, blue  out  COLOR_W each  scaled colour
- brightness  out  4  current brightness (0..15)
- busy  out  1  high while the FSM is not IDLE
- fade_done  out  1  one-cycle pulse when a fade reaches its endpoint

Behaviour:
- Single clock domain. Reset_n is synchronous and active-low; all state is sampled on the Clk rising edge.
- Reset values:
  - rgb_valid, red, green, blue, busy, fade_done all 0.
  - brightness = 15; FSM = IDLE; frame counter = 0.
  - Palette = default table, entries 0..15 grey (R=G=B): 7,B,8,7,6,A,8,C,A,5,9,C,6,7,7,B (hex).
- Lookup pipeline (fixed latency 2, no stall):
  - S1 registers palette[pix_index] and pix_valid.
  - S2 registers each channel as (c * (brightness+1)) >> 4 (8-bit product, truncated to COLOR_W), plus rgb_valid.
  - brightness=15 yields c unchanged; brightness=0 yields 0.
  - When S1 valid=0, the S2 colour outputs are 0.
- Palette write:
  - The entry updates at the edge where wr_en=1.
  - A lookup of the same address in that cycle returns the old value; the next cycle returns the new one.
  - Writes are accepted in any FSM state.
- FSM states: IDLE, FADE_OUT, FADE_IN.
  - fade_out in any state: go to FADE_OUT, clear frame counter. No-op if IDLE and brightness=0.
  - fade_in in any state: go to FADE_IN, clear frame counter. No-op if IDLE and brightness=15.
  - fade_in and fade_out asserted in the same cycle: fade_out wins.
  - A reversal mid-fade keeps the current brightness and restarts frame counting.
  - In FADE_*: each frame_start increments the counter. When the counter reaches FADE_FRAMES-1, it clears and brightness moves 1 toward the target.
  - On the step that reaches the target (0 or 15): go to IDLE and pulse fade_done for that same cycle.
  - frame_start is ignored in IDLE.
  - brightness changes only on frame_start cycles, so it is stable within a frame.
  - A command in the same cycle as frame_start: the command takes effect and that frame_start is not counted.
- busy = (state != IDLE), registered.
- Reset asserted mid-fade returns to the reset values above. The palette also reverts to the default table, discarding any runtime writes.

Optional Feature:
- FLOOR_PAL_WR_EN
  - Defined: the write port is functional as above.
  - Undefined: the palette is the constant default table (synthesises to LUT/ROM), and wr_en/wr_addr/wr_data are ignored.
  - Lookup and fade behaviour are identical in both cases.

Decomposition:
- Package floor_pal_pkg:
  - rgb12_t packed struct {r,g,b}.
  - fade_state_t enum {IDLE, FADE_OUT, FADE_IN}.
  - FLOOR_PAL_DEFAULT constant array [16] of rgb12_t.
  - BRIGHT_MAX = 15.
- One sub-module, floor_pal_scale: the registered per-channel multiply/shift S2 stage, instantiated once for all 3 channels (parameterised by COLOR_W).

Test Plan:
- Reset, then pix_index=7 with pix_valid=1 -> after exactly 2 cycles rgb_valid=1 and rgb={C,C,C}; brightness=15, busy=0.
- FADE_FRAMES=2: fade_out, then 30 frame_starts -> brightness decrements every 2nd frame_start and reaches 0 on the 30th; fade_done pulses once; index 7 then gives {0,0,0}. At brightness=7, index 7 gives {6,6,6}.
- Mid-fade reversal:
  - Brightness=9 in FADE_OUT, fade_in applied -> FADE_IN; the next step after 2 frame_starts gives brightness=10.
  - fade_in and fade_out asserted together -> FADE_OUT.
- Write wr_addr=3, wr_data=F00 while looking up index 3 in the same cycle -> that output is {7,7,7}; a lookup on the next cycle gives {F,0,0}. With FLOOR_PAL_WR_EN undefined it gives {7,7,7}.
- Reset_n=0 for 1 cycle at brightness=4 in FADE_IN after the write above -> brightness=15, busy=0, outputs 0, entry 3 reads {7,7,7}.
- fade_in while IDLE at brightness=15 -> no state change, no fade_done, busy stays 0.

Source files
------------

// File: rtl/floor_pal_pkg.sv
// Shared types and constants for the floor palette fader: colour struct,
// fade FSM states and the default floor grey ramp.
package floor_pal_pkg;

    localparam int BRIGHT_MAX = 15;
    localparam int PAL_DEPTH  = 16;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb12_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FADE_OUT = 2'd1,
        FADE_IN  = 2'd2
    } fade_state_t;

    localparam rgb12_t FLOOR_PAL_DEFAULT [PAL_DEPTH] = '{
        12'h777, 12'hBBB, 12'h888, 12'h777,
        12'h666, 12'hAAA, 12'h888, 12'hCCC,
        12'hAAA, 12'h555, 12'h999, 12'hCCC,
        12'h666, 12'h777, 12'h777, 12'hBBB
    };

    function automatic rgb12_t floor_pal_default(input logic [3:0] idx);
        return FLOOR_PAL_DEFAULT[idx];
    endfunction

endpackage

// File: rtl/floor_pal_scale.sv
// Second lookup stage: scales each colour channel by (brightness+1)/16 and
// registers the result together with the output valid flag.
module floor_pal_scale #(
    parameter int COLOR_W = 4
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic                   in_valid,
    input  logic [3*COLOR_W-1:0]   in_color,
    input  logic [3:0]             brightness,
    output logic                   out_valid,
    output logic [COLOR_W-1:0]     red,
    output logic [COLOR_W-1:0]     green,
    output logic [COLOR_W-1:0]     blue
);

    localparam int PROD_W = COLOR_W + 4;

    // Full-brightness (15) multiplies by 16 and the shift gives the channel back unchanged.
    function automatic logic [COLOR_W-1:0] scale_chan(input logic [COLOR_W-1:0] c,
                                                      input logic [3:0]         b);
        logic [PROD_W-1:0] prod;
        prod = PROD_W'(c) * (PROD_W'(b) + PROD_W'(1));
        return COLOR_W'(prod >> 4);
    endfunction

    // Register scaled channels; an invalid request produces black.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            out_valid <= 1'b0;
            red       <= '0;
            green     <= '0;
            blue      <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                red   <= scale_chan(in_color[3*COLOR_W-1 -: COLOR_W], brightness);
                green <= scale_chan(in_color[2*COLOR_W-1 -: COLOR_W], brightness);
                blue  <= scale_chan(in_color[COLOR_W-1   -: COLOR_W], brightness);
            end else begin
                red   <= '0;
                green <= '0;
                blue  <= '0;
            end
        end
    end

endmodule

// File: rtl/floor_palette_fader.sv
// Floor-layer palette controller: 16-entry palette lookup through a 2-stage
// pipeline, with a global brightness fade stepped every FADE_FRAMES frames.
// Build option FLOOR_PAL_WR_EN: when defined the palette is runtime-writable,
// otherwise it is the constant default ramp and the write port is ignored.
module floor_palette_fader
    import floor_pal_pkg::*;
#(
    parameter int FADE_FRAMES = 4,
    parameter int IDX_W       = 4,
    parameter int COLOR_W     = 4
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic                   frame_start,
    input  logic                   pix_valid,
    input  logic [IDX_W-1:0]       pix_index,
    input  logic                   wr_en,
    input  logic [IDX_W-1:0]       wr_addr,
    input  logic [3*COLOR_W-1:0]   wr_data,
    input  logic                   fade_in,
    input  logic                   fade_out,
    output logic                   rgb_valid,
    output logic [COLOR_W-1:0]     red,
    output logic [COLOR_W-1:0]     green,
    output logic [COLOR_W-1:0]     blue,
    output logic [3:0]             brightness,
    output logic                   busy,
    output logic                   fade_done
);

    localparam int PIX_W = 3 * COLOR_W;
    localparam int DEPTH = 2 ** IDX_W;
    localparam int CNT_W = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(FADE_FRAMES - 1);
    localparam logic [3:0]       BRIGHT_TOP = 4'(BRIGHT_MAX);

    function automatic logic [PIX_W-1:0] default_color(input logic [IDX_W-1:0] idx);
        rgb12_t e;
        e = floor_pal_default(4'(idx));
        return {COLOR_W'(e.r), COLOR_W'(e.g), COLOR_W'(e.b)};
    endfunction

    logic [PIX_W-1:0] lookup_color;
    logic             s1_valid;
    logic [PIX_W-1:0] s1_color;

    fade_state_t      state_q, state_n;
    logic [3:0]       bright_q, bright_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic             hit_target;
    logic             busy_q, busy_n;
    logic             done_q, done_n;

`ifdef FLOOR_PAL_WR_EN
    logic [PIX_W-1:0] pal [DEPTH];

    // Writable palette; reset restores the default ramp and drops runtime writes.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pal[i] <= default_color(IDX_W'(i));
            end
        end else if (wr_en) begin
            pal[wr_addr] <= wr_data;
        end
    end

    assign lookup_color = pal[pix_index];
`else
    logic unused_wr;

    assign unused_wr    = ^{wr_en, wr_addr, wr_data};
    assign lookup_color = default_color(pix_index);
`endif

    // Stage 1: capture the palette entry (pre-write value) and the request qualifier.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            s1_valid <= 1'b0;
            s1_color <= '0;
        end else begin
            s1_valid <= pix_valid;
            s1_color <= lookup_color;
        end
    end

    floor_pal_scale #(
        .COLOR_W (COLOR_W)
    ) u_scale (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .in_valid   (s1_valid),
        .in_color   (s1_color),
        .brightness (bright_q),
        .out_valid  (rgb_valid),
        .red        (red),
        .green      (green),
        .blue       (blue)
    );

    // Fade state, brightness, frame counter and registered status flags.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q  <= IDLE;
            bright_q <= BRIGHT_TOP;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_n;
            bright_q <= bright_n;
            cnt_q    <= cnt_n;
            busy_q   <= busy_n;
            done_q   <= done_n;
        end
    end

    // Commands take priority over frame counting; fade_out beats fade_in.
    always_comb begin
        state_n    = state_q;
        bright_n   = bright_q;
        cnt_n      = cnt_q;
        hit_target = 1'b0;
        if (fade_out) begin
            if (!(state_q == IDLE && bright_q == 4'd0)) begin
                state_n = FADE_OUT;
                cnt_n   = '0;
            end
        end else if (fade_in) begin
            if (!(state_q == IDLE && bright_q == BRIGHT_TOP)) begin
                state_n = FADE_IN;
                cnt_n   = '0;
            end
        end else if (frame_start && state_q != IDLE) begin
            if (cnt_q == CNT_LAST) begin
                cnt_n = '0;
                if (state_q == FADE_OUT) begin
                    if (bright_q != 4'd0) begin
                        bright_n = bright_q - 4'd1;
                    end
                    hit_target = (bright_q <= 4'd1);
                end else begin
                    if (bright_q != BRIGHT_TOP) begin
                        bright_n = bright_q + 4'd1;
                    end
                    hit_target = (bright_q >= BRIGHT_TOP - 4'd1);
                end
                if (hit_target) begin
                    state_n = IDLE;
                end
            end else begin
                cnt_n = cnt_q + 1'b1;
            end
        end
    end

    // Status flags derived from the upcoming state and endpoint step.
    always_comb begin
        busy_n = (state_n != IDLE);
        done_n = hit_target;
    end

    assign brightness = bright_q;
    assign busy       = busy_q;
    assign fade_done  = done_q;

endmodule
